// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: widths, FSM state encodings,
// handshake levels and the operand magnitude helper.
package div_pkg;

    localparam int DATA_W = 32;
    localparam int HILO_W = 2 * DATA_W;
    localparam int CNT_W  = 6;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
        return (is_signed && v[DATA_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div.sv
// Restoring divider producing one quotient bit per cycle; result is
// {remainder, quotient} for the HI/LO registers, held until start_i drops.
module div
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [HILO_W-1:0] result_o,
    output logic              ready_o
);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*DATA_W:0] dividend_q;
    logic [DATA_W-1:0] divisor_q;
    logic              neg_quot_q;
    logic              neg_rem_q;
    logic [HILO_W-1:0] result_q;
    logic              ready_q;

    logic [DATA_W:0]   diff_d;
    logic [2*DATA_W:0] step_d;
    logic [DATA_W-1:0] quot_d;
    logic [DATA_W-1:0] rem_d;
    logic              unused_top;

    // Partial remainder sits in the upper half; diff_d[DATA_W] is the borrow.
    assign diff_d = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    assign step_d = diff_d[DATA_W] ? {dividend_q[2*DATA_W-1:0], 1'b0}
                                   : {diff_d[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};

    assign quot_d = neg_quot_q ? -step_d[DATA_W-1:0] : step_d[DATA_W-1:0];
    assign rem_d  = neg_rem_q  ? -step_d[2*DATA_W:DATA_W+1] : step_d[2*DATA_W:DATA_W+1];

    // The remainder never reaches bit 2*DATA_W before the final step.
    assign unused_top = dividend_q[2*DATA_W];

    // NOTE: all state below updates with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            case (state_q)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q    <= DivOn;
                            cnt_q      <= '0;
                            dividend_q <= {{(DATA_W-1){1'b0}},
                                           abs_val(opdata1_i, signed_div_i), 1'b0};
                            divisor_q  <= abs_val(opdata2_i, signed_div_i);
                            neg_quot_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem_q  <= signed_div_i & opdata1_i[DATA_W-1];
                        end
                    end
                end
                DivByZero: begin
                    if (annul_i) begin
                        state_q <= DivFree;
                    end else begin
                        state_q  <= DivEnd;
                        result_q <= '0;
                        ready_q  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        state_q <= DivFree;
                        cnt_q   <= '0;
                    end else begin
                        dividend_q <= step_d;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        // Last quotient bit: fix up signs in the same edge.
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_q  <= DivEnd;
                            result_q <= {rem_d, quot_d};
                            ready_q  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_q  <= DivFree;
                        cnt_q    <= '0;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end
                end
                default: begin
                    state_q <= DivFree;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 DATA_W, 32, operand width; result_o is 2*DATA_W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 signed_div_i  input  1  1 = operands are two's-complement signed; 0 = unsigned.
REQ-005 opdata1_i  input  DATA_W  dividend; sampled only on an accepted start.
REQ-006 opdata2_i  input  DATA_W  divisor; sampled only on an accepted start.
REQ-007 start_i  input  1  request from EX stage; level-held until result consumed.
REQ-008 annul_i  input  1  abort the in-flight division (pipeline flush).
REQ-009 result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; drives HI/LO write data.
REQ-010 ready_o  output  1  result_o valid; EX stage releases its stall on this.

Function
REQ-011 The block SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 FREE: start_i=1, annul_i=0, opdata2_i!=0 SHALL latch operands and go to ON; opdata2_i==0 SHALL go to BYZERO; otherwise stay FREE.
REQ-013 BYZERO SHALL go to END in one cycle with quotient and remainder both zero.
REQ-014 ON SHALL perform restoring division, one quotient bit per cycle, MSB first, for exactly DATA_W cycles, tracked by a 6-bit counter cleared on entry.
REQ-015 ON, counter reaching DATA_W SHALL apply sign fix-up and go to END.
REQ-016 END SHALL hold ready_o=1 and result_o stable while start_i=1; start_i=0 SHALL go to FREE with ready_o=0 and result_o=0 on the next cycle.
REQ-017 Latency: start accepted in cycle t, nonzero divisor -> ready_o=1 in cycle t+33; zero divisor -> ready_o=1 in cycle t+2.
REQ-018 ready_o and result_o SHALL be registered; ready_o=1 only in END.
REQ-019 Signed mode SHALL divide absolute values; quotient negated when operand signs differ; remainder takes the sign of the dividend.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL wrap modulo 2^DATA_W: quotient 0x80000000, remainder 0.
REQ-021 annul_i=1 in ON or BYZERO SHALL go to FREE next cycle; ready_o stays 0; no result is produced.
REQ-022 annul_i=1 in FREE SHALL block acceptance of start_i in that cycle.
REQ-023 start_i and operand changes during ON/BYZERO/END SHALL be ignored, except start_i=0 in END per REQ-016.
REQ-024 Unsigned mode SHALL treat all DATA_W bits as magnitude (0xFFFFFFFF / 1 = 0xFFFFFFFF).

Reset
REQ-025 rst=0 at a clock edge SHALL force FREE, ready_o=0, result_o=0, counter=0, in any state including mid-ON.
REQ-026 The first start_i after rst returns to 1 SHALL be accepted normally with no residue from an aborted division.

Structure
REQ-027 The state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/DivResultNotReady, DivStart/DivStop, and the HI/LO width macros SHALL live in the shared defines header.
REQ-028 The block SHALL be a single module with no sub-module; dividend/divisor registers, the 2*DATA_W+1-bit partial-remainder datapath, and sign fix-up are inline.

Verification
REQ-029 Unsigned 100/7, start at t -> ready_o=1 at t+33, result_o=0x00000002_0000000E.
REQ-030 Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> 0x00000001_FFFFFFFD.
REQ-031 Divisor 0, start at t -> ready_o=1 at t+2, result_o=0; start_i dropped -> ready_o=0 next cycle.
REQ-032 annul_i pulsed at t+10 of an ON division -> FREE at t+11, ready_o never asserts; a new 9/3 then yields 0x00000000_00000003.
REQ-033 rst=0 at t+20 mid-ON -> all outputs 0 next cycle; after release, 0xFFFFFFFF/1 unsigned -> 0x00000000_FFFFFFFF.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000; held in END while start_i=1 for 5 cycles.
